// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared divisor constants and helpers for the baud generator
package baud_pkg;

    // 50 MHz system clock, 16x oversampling: integer part and 1/16 fractional part
    localparam int BAUD_9600_INT    = 325;
    localparam int BAUD_9600_FRAC   = 8;
    localparam int BAUD_115200_INT  = 27;
    localparam int BAUD_115200_FRAC = 2;
    localparam int BAUD_921600_INT  = 3;
    localparam int BAUD_921600_FRAC = 6;

    localparam int OVS_DEFAULT = 16;

    function automatic int half_ovs(input int ovs);
        return ovs / 2;
    endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// rtl/baud_tick_gen_if.sv - control and tick signals of the baud generator
interface baud_tick_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) ();
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_pend;
    logic              os_tick;
    logic              baud_tick;
    logic              baud_clk;

    modport master (
        output en, div_int, div_frac, div_load,
        input  div_pend, os_tick, baud_tick, baud_clk
    );

    modport slave (
        input  en, div_int, div_frac, div_load,
        output div_pend, os_tick, baud_tick, baud_clk
    );
endinterface

// File: rtl/baud_os_div.sv
// rtl/baud_os_div.sv - fractional oversample divider with double-buffered divisor
module baud_os_div
    import baud_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int DEF_INT  = BAUD_115200_INT,
    parameter int DEF_FRAC = BAUD_115200_FRAC
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_pend,
    output logic              os_tick,
    output logic              tick_next
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_q, pend_d;
    logic              os_tick_q, os_tick_d;

    logic              apply;
    logic [DIV_W-1:0]  new_int;
    logic [FRAC_W-1:0] new_frac;
    logic [FRAC_W:0]   frac_sum;

    always_comb begin
        // An idle generator is permanently at a boundary, so pending values land at once
        apply    = pend_q && (!en || (cnt_q == '0));
        new_int  = apply ? pend_int_q  : act_int_q;
        new_frac = apply ? pend_frac_q : act_frac_q;
        frac_sum = {1'b0, acc_q} + {1'b0, new_frac};

        act_int_d   = new_int;
        act_frac_d  = new_frac;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_d      = pend_q & ~apply;
        if (div_load) begin
            pend_int_d  = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
            pend_frac_d = div_frac;
            pend_d      = 1'b1;
        end

        cnt_d     = cnt_q;
        acc_d     = acc_q;
        os_tick_d = 1'b0;
        if (!en) begin
            cnt_d = new_int - DIV_W'(1);
            acc_d = '0;
        end else if (cnt_q == '0) begin
            os_tick_d = 1'b1;
            acc_d     = frac_sum[FRAC_W-1:0];
            cnt_d     = new_int - DIV_W'(1) + {{(DIV_W-1){1'b0}}, frac_sum[FRAC_W]};
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= DIV_W'(DEF_INT - 1);
            acc_q       <= '0;
            act_int_q   <= DIV_W'(DEF_INT);
            act_frac_q  <= FRAC_W'(DEF_FRAC);
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_q      <= 1'b0;
            os_tick_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_q      <= pend_d;
            os_tick_q   <= os_tick_d;
        end
    end

    assign div_pend  = pend_q;
    assign os_tick   = os_tick_q;
    assign tick_next = os_tick_d;

endmodule

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - oversample tick, bit tick and square baud clock from one divider
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = OVS_DEFAULT,
    parameter int DEF_INT  = BAUD_115200_INT,
    parameter int DEF_FRAC = BAUD_115200_FRAC
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    baud_tick_gen_if.slave  bus
);

    localparam int OCW  = $clog2(OVS);
    localparam int HALF = half_ovs(OVS);

    logic           tick_next;
    logic [OCW-1:0] os_cnt_q, os_cnt_d;
    logic           baud_tick_q, baud_tick_d;
    logic           baud_clk_q, baud_clk_d;

    baud_os_div #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .DEF_INT  (DEF_INT),
        .DEF_FRAC (DEF_FRAC)
    ) u_os_div (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .en        (bus.en),
        .div_int   (bus.div_int),
        .div_frac  (bus.div_frac),
        .div_load  (bus.div_load),
        .div_pend  (bus.div_pend),
        .os_tick   (bus.os_tick),
        .tick_next (tick_next)
    );

    // Phase logic follows the divider's next-state tick so all outputs register on the same edge
    always_comb begin
        os_cnt_d    = os_cnt_q;
        baud_tick_d = 1'b0;
        baud_clk_d  = baud_clk_q;
        if (!bus.en) begin
            os_cnt_d   = '0;
            baud_clk_d = 1'b0;
        end else if (tick_next) begin
            if (os_cnt_q == OCW'(OVS - 1)) begin
                os_cnt_d    = '0;
                baud_tick_d = 1'b1;
            end else begin
                os_cnt_d = os_cnt_q + OCW'(1);
            end
            if ((os_cnt_q == OCW'(OVS - 1)) || (os_cnt_q == OCW'(HALF - 1))) begin
                baud_clk_d = ~baud_clk_q;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt_q    <= '0;
            baud_tick_q <= 1'b0;
            baud_clk_q  <= 1'b0;
        end else begin
            os_cnt_q    <= os_cnt_d;
            baud_tick_q <= baud_tick_d;
            baud_clk_q  <= baud_clk_d;
        end
    end

    assign bus.baud_tick = baud_tick_q;
    assign bus.baud_clk  = baud_clk_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - self-checking bench for baud_tick_gen
module tb_baud_tick_gen;

    localparam int FRAC_STEPS = 16;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;

    int   os_q[$];
    int   bt_q[$];
    int   rise_q[$];
    int   fall_q[$];
    int   pend_clr = 0;
    logic bclk_prev = 1'b0;
    logic pend_prev = 1'b0;

    baud_tick_gen_if #(.DIV_W(16), .FRAC_W(4)) bus ();

    baud_tick_gen dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (bus.os_tick === 1'b1)   os_q.push_back(cyc);
        if (bus.baud_tick === 1'b1) bt_q.push_back(cyc);
        if (bus.baud_clk === 1'b1 && bclk_prev === 1'b0) rise_q.push_back(cyc);
        if (bus.baud_clk === 1'b0 && bclk_prev === 1'b1) fall_q.push_back(cyc);
        if (bus.div_pend === 1'b0 && pend_prev === 1'b1) pend_clr <= pend_clr + 1;
        bclk_prev <= bus.baud_clk;
        pend_prev <= bus.div_pend;
    end

    // Edge count (relative to the cycle en was raised) at which the k-th os_tick is seen
    function automatic int tick_time(input int c0, input int di, input int fr, input int k);
        return c0 + k * di + ((k - 1) * fr) / FRAC_STEPS;
    endfunction

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic clear_q();
        os_q.delete();
        bt_q.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic do_reset();
        bus.en = 1'b0;
        bus.div_load = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_q();
        pend_clr = 0;
    endtask

    task automatic load(input int i, input int f);
        bus.div_int  = 16'(i);
        bus.div_frac = 4'(f);
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
    endtask

    task automatic collect(input int n, input int budget, input string tag);
        int b = 0;
        while (os_q.size() < n && b < budget) begin
            step();
            b++;
        end
        total++;
        if (os_q.size() < n) begin
            $display("FAIL %s_timeout ticks=%0d required=%0d", tag, os_q.size(), n);
            bad++;
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0;
        bus.div_int = '0;
        bus.div_frac = '0;
        bus.div_load = 1'b0;
        rst_n = 1'b0;
        step();
        total += 4;
        if (bus.os_tick !== 1'b0)   begin bad++; $display("FAIL reset_os_tick got=%b exp=0", bus.os_tick); end
        if (bus.baud_tick !== 1'b0) begin bad++; $display("FAIL reset_baud_tick got=%b exp=0", bus.baud_tick); end
        if (bus.baud_clk !== 1'b0)  begin bad++; $display("FAIL reset_baud_clk got=%b exp=0", bus.baud_clk); end
        if (bus.div_pend !== 1'b0)  begin bad++; $display("FAIL reset_div_pend got=%b exp=0", bus.div_pend); end
        step();
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic test_defaults();
        int c0;
        int longs;
        do_reset();
        bus.en = 1'b1;
        c0 = cyc;
        collect(33, 1200, "defaults");
        for (int k = 1; k <= 33; k++) begin
            total++;
            if (os_q[k-1] !== tick_time(c0, 27, 2, k)) begin
                bad++;
                $display("FAIL def_tick%0d got=%0d exp=%0d", k, os_q[k-1], tick_time(c0, 27, 2, k));
            end
        end
        longs = 0;
        for (int j = 1; j <= 16; j++) if (os_q[j] - os_q[j-1] == 28) longs++;
        total++;
        if (longs !== 2) begin bad++; $display("FAIL def_long_periods got=%0d exp=2", longs); end
        total += 4;
        if (bt_q.size() < 2 || bt_q[1] - bt_q[0] !== 434) begin
            bad++; $display("FAIL def_baud_spacing got=%0d exp=434", bt_q[1] - bt_q[0]);
        end
        if (bt_q[0] !== tick_time(c0, 27, 2, 16)) begin
            bad++; $display("FAIL def_baud_first got=%0d exp=%0d", bt_q[0], tick_time(c0, 27, 2, 16));
        end
        if (rise_q.size() < 2 || rise_q[1] - rise_q[0] !== 434) begin
            bad++; $display("FAIL def_bclk_period got=%0d exp=434", rise_q[1] - rise_q[0]);
        end
        if (fall_q.size() < 1 || fall_q[0] - rise_q[0] < 216 || fall_q[0] - rise_q[0] > 218) begin
            bad++; $display("FAIL def_bclk_high got=%0d exp=217+-1", fall_q[0] - rise_q[0]);
        end
    endtask

    task automatic test_load_mid();
        int c0;
        int t1;
        logic pend_before;
        do_reset();
        bus.en = 1'b1;
        c0 = cyc;
        repeat ($urandom_range(3, 20)) step();
        load(4, 0);
        total++;
        if (bus.div_pend !== 1'b1) begin bad++; $display("FAIL mid_pend_set got=%b exp=1", bus.div_pend); end
        pend_before = bus.div_pend;
        for (int b = 0; b < 40 && os_q.size() == 0; b++) begin
            pend_before = bus.div_pend;
            step();
        end
        total += 3;
        if (pend_before !== 1'b1) begin bad++; $display("FAIL mid_pend_hold got=%b exp=1", pend_before); end
        if (bus.div_pend !== 1'b0) begin bad++; $display("FAIL mid_pend_clear got=%b exp=0", bus.div_pend); end
        if (os_q.size() == 0 || os_q[0] !== c0 + 27) begin
            bad++; $display("FAIL mid_first_tick got=%0d exp=%0d", os_q[0], c0 + 27);
        end
        t1 = os_q[0];
        collect(33, 400, "mid");
        for (int j = 1; j < 33; j++) begin
            total++;
            if (os_q[j] - os_q[j-1] !== 4) begin
                bad++; $display("FAIL mid_spacing%0d got=%0d exp=4", j, os_q[j] - os_q[j-1]);
            end
        end
        total += 2;
        if (bt_q[0] !== t1 + 15 * 4) begin bad++; $display("FAIL mid_baud_first got=%0d exp=%0d", bt_q[0], t1 + 60); end
        if (bt_q[1] - bt_q[0] !== 64) begin bad++; $display("FAIL mid_baud_spacing got=%0d exp=64", bt_q[1] - bt_q[0]); end
    endtask

    task automatic test_clamp();
        int c0;
        do_reset();
        load($urandom_range(0, 1), 0);
        total += 2;
        if (bus.div_pend !== 1'b1) begin bad++; $display("FAIL clamp_pend_set got=%b exp=1", bus.div_pend); end
        step();
        if (bus.div_pend !== 1'b0) begin bad++; $display("FAIL clamp_applied got=%b exp=0", bus.div_pend); end
        bus.en = 1'b1;
        c0 = cyc;
        collect(8, 100, "clamp");
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (os_q[k-1] !== c0 + 2 * k) begin
                bad++; $display("FAIL clamp_tick%0d got=%0d exp=%0d", k, os_q[k-1], c0 + 2 * k);
            end
        end
    endtask

    task automatic test_back_to_back_load();
        int c0;
        do_reset();
        bus.en = 1'b1;
        c0 = cyc;
        step();
        step();
        load(10, 0);
        step();
        step();
        load(20, 0);
        collect(3, 200, "b2b");
        total += 5;
        if (os_q[0] !== c0 + 27) begin bad++; $display("FAIL b2b_tick1 got=%0d exp=%0d", os_q[0], c0 + 27); end
        if (os_q[1] !== c0 + 47) begin bad++; $display("FAIL b2b_tick2 got=%0d exp=%0d", os_q[1], c0 + 47); end
        if (os_q[2] !== c0 + 67) begin bad++; $display("FAIL b2b_tick3 got=%0d exp=%0d", os_q[2], c0 + 67); end
        if (pend_clr !== 1) begin bad++; $display("FAIL b2b_pend_clears got=%0d exp=1", pend_clr); end
        if (bus.div_pend !== 1'b0) begin bad++; $display("FAIL b2b_pend_final got=%b exp=0", bus.div_pend); end
    endtask

    task automatic test_en_gap();
        int c0;
        int n0;
        int gap_bad;
        do_reset();
        bus.en = 1'b1;
        collect(10, 400, "gap_pre");
        step();
        step();
        step();
        total++;
        if (bus.baud_clk !== 1'b1) begin bad++; $display("FAIL gap_bclk_before got=%b exp=1", bus.baud_clk); end
        bus.en = 1'b0;
        n0 = os_q.size();
        gap_bad = 0;
        repeat (5) begin
            step();
            if (bus.os_tick !== 1'b0 || bus.baud_tick !== 1'b0 || bus.baud_clk !== 1'b0) gap_bad++;
        end
        total += 2;
        if (gap_bad !== 0) begin bad++; $display("FAIL gap_quiet got=%0d exp=0", gap_bad); end
        if (os_q.size() !== n0) begin bad++; $display("FAIL gap_ticks got=%0d exp=%0d", os_q.size(), n0); end
        bus.en = 1'b1;
        c0 = cyc;
        clear_q();
        collect(16, 600, "gap_post");
        total += 3;
        if (os_q[0] !== c0 + 27) begin bad++; $display("FAIL gap_first_tick got=%0d exp=%0d", os_q[0], c0 + 27); end
        if (bt_q.size() !== 1 || bt_q[0] !== tick_time(c0, 27, 2, 16)) begin
            bad++; $display("FAIL gap_baud_phase got=%0d exp=%0d", bt_q[0], tick_time(c0, 27, 2, 16));
        end
        if (rise_q.size() < 1 || rise_q[0] !== tick_time(c0, 27, 2, 8)) begin
            bad++; $display("FAIL gap_bclk_rise got=%0d exp=%0d", rise_q[0], tick_time(c0, 27, 2, 8));
        end
    endtask

    task automatic test_async_reset();
        int c0;
        do_reset();
        bus.en = 1'b1;
        collect(9, 400, "arst_pre");
        load(5, 0);
        total += 2;
        if (bus.baud_clk !== 1'b1) begin bad++; $display("FAIL arst_bclk_before got=%b exp=1", bus.baud_clk); end
        if (bus.div_pend !== 1'b1) begin bad++; $display("FAIL arst_pend_before got=%b exp=1", bus.div_pend); end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (bus.os_tick !== 1'b0)   begin bad++; $display("FAIL arst_os_tick got=%b exp=0", bus.os_tick); end
        if (bus.baud_tick !== 1'b0) begin bad++; $display("FAIL arst_baud_tick got=%b exp=0", bus.baud_tick); end
        if (bus.baud_clk !== 1'b0)  begin bad++; $display("FAIL arst_baud_clk got=%b exp=0", bus.baud_clk); end
        if (bus.div_pend !== 1'b0)  begin bad++; $display("FAIL arst_div_pend got=%b exp=0", bus.div_pend); end
        step();
        rst_n = 1'b1;
        c0 = cyc;
        clear_q();
        collect(2, 100, "arst_post");
        total += 2;
        if (os_q[0] !== c0 + 27) begin bad++; $display("FAIL arst_tick1 got=%0d exp=%0d", os_q[0], c0 + 27); end
        if (os_q[1] !== tick_time(c0, 27, 2, 2)) begin
            bad++; $display("FAIL arst_tick2 got=%0d exp=%0d", os_q[1], tick_time(c0, 27, 2, 2));
        end
    endtask

    task automatic test_random_div();
        int c0;
        int di;
        int fr;
        for (int it = 0; it < 5; it++) begin
            do_reset();
            di = $urandom_range(2, 9);
            fr = $urandom_range(0, 15);
            load(di, fr);
            step();
            bus.en = 1'b1;
            c0 = cyc;
            clear_q();
            collect(33, 500, "rand");
            for (int k = 1; k <= 33; k++) begin
                total++;
                if (os_q[k-1] !== tick_time(c0, di, fr, k)) begin
                    bad++;
                    $display("FAIL rand_tick it=%0d div=%0d.%0d k=%0d got=%0d exp=%0d",
                             it, di, fr, k, os_q[k-1], tick_time(c0, di, fr, k));
                end
            end
            total += 2;
            if (bt_q[0] !== tick_time(c0, di, fr, 16)) begin
                bad++; $display("FAIL rand_baud0 it=%0d got=%0d exp=%0d", it, bt_q[0], tick_time(c0, di, fr, 16));
            end
            if (bt_q[1] !== tick_time(c0, di, fr, 32)) begin
                bad++; $display("FAIL rand_baud1 it=%0d got=%0d exp=%0d", it, bt_q[1], tick_time(c0, di, fr, 32));
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_load_mid();
        test_clamp();
        test_back_to_back_load();
        test_en_gap();
        test_async_reset();
        test_random_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate generator for the UART datapath. It replaces the fixed 50 MHz→115200 toggle divider with three outputs from one fractional divider:
- a runtime-programmable oversample tick for the receiver,
- a bit-rate tick for the transmitter,
- a 50 %-duty baud clock for legacy consumers.

It sits between the system clock domain and the tx/rx engines.

## Interface
Parameters:
- DIV_W, 16, width of integer divisor.
- FRAC_W, 4, width of fractional divisor (step = 1/2^FRAC_W cycle).
- OVS, 16, oversample factor (even, ≥4).
- DEF_INT, 27, reset value of active integer divisor (50 MHz, 115200×16).
- DEF_FRAC, 2, reset value of active fractional divisor.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low holds the generator idle.
- div_int  in  DIV_W  requested integer divisor (values <2 clamp to 2).
- div_frac  in  FRAC_W  requested fractional divisor.
- div_load  in  1  single-cycle strobe; captures div_int/div_frac.
- div_pend  out  1  high while a captured divisor awaits application.
- os_tick  out  1  one-cycle pulse at OVS × baud rate.
- baud_tick  out  1  one-cycle pulse at baud rate, coincident with every OVS-th os_tick.
- baud_clk  out  1  square wave at baud rate.

## Operation
- Active divisor registers (act_int, act_frac) reset to DEF_INT/DEF_FRAC.
- Pending registers capture div_load data and set div_pend.
- Down-counter cnt and fractional accumulator acc (FRAC_W bits) form one oversample period. The period is act_int cycles, or act_int+1 when acc+act_frac overflows 2^FRAC_W. acc keeps the wrapped sum.
- When cnt reaches 0 with en=1:
  - os_tick pulses.
  - If div_pend is set, the pending divisor moves to active and div_pend clears. The new value governs the next period.
  - cnt reloads to (period−1).
- Phase counter os_cnt (0..OVS−1) increments on each os_tick and wraps.
- baud_tick pulses with the os_tick on which os_cnt==OVS−1.
- baud_clk toggles on the os_tick at os_cnt==OVS/2−1 and on the one at os_cnt==OVS−1.
- While en=0:
  - cnt = act_int−1, acc=0, os_cnt=0, baud_clk=0.
  - os_tick and baud_tick are 0.
  - A pending divisor is applied immediately, in the cycle after div_load.
- div_load while div_pend=1 overwrites the pending value; only the latest load is applied.
- div_load in the same cycle as an application boundary: the old pending value is applied, and the new value becomes pending.
- Clamping: a requested div_int of 0 or 1 is stored as 2.

## Timing
- Reset values: os_tick=0, baud_tick=0, baud_clk=0, div_pend=0, act_int=DEF_INT, act_frac=DEF_FRAC, acc=0, os_cnt=0.
- All outputs are registered; no combinational path from inputs to outputs.
- First os_tick occurs act_int cycles after the first sys_clk edge sampling en=1. acc starts at 0, so the first period has no carry unless act_frac overflows alone (impossible).
- Consecutive os_tick spacing: act_int or act_int+1 cycles. Over 2^FRAC_W periods, exactly act_frac periods are long.
- baud_tick spacing: sum of OVS oversample periods. For defaults: 16×27 + 2 = 434 cycles.
- Deasserting en takes effect on the next edge. The in-flight period is abandoned, and no pulse is generated on that edge.
- Asynchronous reset mid-period: all state returns to reset values immediately. Operation restarts from a full act_int period once rst_n deasserts and en=1.

## Structure
- Shared package baud_pkg:
  - default divisor constants for 50 MHz at 9600/115200/921600 (×16);
  - localparam helpers for OVS/2.
- Sub-module baud_os_div holds cnt, acc, the active/pending divisor registers, and os_tick generation.
- The top level adds os_cnt, baud_tick and baud_clk.

## Test plan
- Reset release with en=1 and defaults:
  - first os_tick at cycle 27;
  - over 16 os_ticks, exactly two 28-cycle periods;
  - baud_tick spacing 434 cycles;
  - baud_clk period 434 cycles, high phase 217±1.
- div_load of div_int=4, div_frac=0 mid-period:
  - div_pend=1 until the next os_tick;
  - afterwards os_tick spacing is exactly 4;
  - baud_tick spacing is 64.
- div_int=1 loaded with en=0: applied the next cycle; after en=1, os_tick spacing is 2 (clamped).
- Two div_load strobes (div_int 10, then 20) within one period: only 20 is applied; div_pend clears once.
- en dropped for 5 cycles mid-period:
  - no ticks during the gap;
  - baud_clk=0 and os_cnt=0 after the gap;
  - first os_tick act_int cycles after en returns.
- rst_n asserted mid-period, asynchronously between edges: all outputs 0 immediately, act_int returns to 27, div_pend=0.
